// File: rtl/spike_train_decoder.sv
// ============================================================================
// Module   : spike_train_decoder
// Brief    : Hysteretic spike detector with ISI measurement, ISI FIFO and
//            saturating spike counter. Optional burst detector enabled by
//            defining SPIKE_TRAIN_DECODER_BURST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spike_train_decoder #(
  parameter int                ISI_W      = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic signed [7:0] THR_HI     = 8'sh13,
  parameter logic signed [7:0] THR_LO     = 8'sh00,
  parameter logic [ISI_W-1:0]  BURST_ISI  = ISI_W'(8),
  parameter int                BURST_MIN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       v_in,
  input  logic             clear_stats,
  output logic             spike,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic [ISI_W-1:0] spike_count,
  output logic             overflow,
  output logic             burst
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    C_DEPTH = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]    C_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {ARMED = 1'b0, FIRED = 1'b1} state_t;

  state_t           state_q;
  logic             spike_q;
  logic [ISI_W-1:0] isi_q;
  logic [ISI_W-1:0] cnt_q;
  logic             have_ref_q;
  logic             ovf_q;
  logic [ISI_W-1:0] head_q;
  logic [AW:0]      count_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [ISI_W-1:0] mem_q [FIFO_DEPTH];

  logic          fire_w;
  logic          rearm_w;
  logic          push_w;
  logic          pop_w;
  logic          full_w;
  logic          wr_en_w;
  logic [AW-1:0] rd_nxt_w;

  assign fire_w   = en && (state_q == ARMED) && ($signed(v_in) > THR_HI);
  assign rearm_w  = en && (state_q == FIRED) && ($signed(v_in) < THR_LO);
  assign push_w   = fire_w && !clear_stats && have_ref_q;
  assign pop_w    = isi_valid && isi_ready;
  assign full_w   = (count_q == C_DEPTH);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_w  = push_w && (!full_w || pop_w);
  assign rd_nxt_w = rd_q + 1'b1;

  assign spike       = spike_q;
  assign isi_data    = head_q;
  assign isi_valid   = (count_q != '0);
  assign spike_count = cnt_q;
  assign overflow    = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARMED;
      spike_q    <= 1'b0;
      isi_q      <= '0;
      cnt_q      <= '0;
      have_ref_q <= 1'b0;
      ovf_q      <= 1'b0;
      head_q     <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      spike_q <= fire_w;
      if (fire_w) begin
        state_q <= FIRED;
      end else if (rearm_w) begin
        state_q <= ARMED;
      end

      if (clear_stats) begin
        isi_q      <= '0;
        cnt_q      <= '0;
        have_ref_q <= 1'b0;
        ovf_q      <= 1'b0;
        head_q     <= '0;
        count_q    <= '0;
        rd_q       <= '0;
        wr_q       <= '0;
      end else begin
        if (fire_w) begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          have_ref_q <= 1'b1;
          isi_q      <= ISI_W'(1);
        end else if (en && (isi_q != '1)) begin
          isi_q <= isi_q + 1'b1;
        end

        if (push_w && full_w && !pop_w) ovf_q <= 1'b1;
        if (wr_en_w) wr_q <= wr_q + 1'b1;
        if (pop_w)   rd_q <= rd_nxt_w;

        case ({wr_en_w, pop_w})
          2'b10:   count_q <= count_q + C_ONE;
          2'b01:   count_q <= count_q - C_ONE;
          default: count_q <= count_q;
        endcase

        // Head register tracks the entry at the read pointer after this edge.
        if (pop_w && (count_q > C_ONE)) begin
          head_q <= mem_q[rd_nxt_w];
        end else if (wr_en_w && ((count_q == '0) || pop_w)) begin
          head_q <= isi_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_w) mem_q[wr_q] <= isi_q;
  end

`ifdef SPIKE_TRAIN_DECODER_BURST_EN
  localparam logic [ISI_W-1:0] C_BURST_MIN = ISI_W'(BURST_MIN);

  logic             burst_q;
  logic [ISI_W-1:0] bcnt_q;
  logic [ISI_W-1:0] bcnt_nxt_w;

  assign bcnt_nxt_w = (bcnt_q == '1) ? bcnt_q : bcnt_q + 1'b1;
  assign burst      = burst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (clear_stats) begin
      burst_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (wr_en_w) begin
      if (isi_q <= BURST_ISI) begin
        bcnt_q <= bcnt_nxt_w;
        if (bcnt_nxt_w >= C_BURST_MIN) burst_q <= 1'b1;
      end else begin
        bcnt_q  <= '0;
        burst_q <= 1'b0;
      end
    end
  end
`else
  logic unused_burst_cfg;
  assign unused_burst_cfg = ^{BURST_ISI, (BURST_MIN != 0)};
  assign burst            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spike_train_decoder.sv
// ============================================================================
// Module   : tb_spike_train_decoder
// Brief    : Directed self-checking bench for spike_train_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spike_train_decoder;

`ifdef SPIKE_TRAIN_DECODER_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  v_in = 8'h00;
  logic        clear_stats = 1'b0;
  logic        isi_ready = 1'b0;
  logic        spike;
  logic [15:0] isi_data;
  logic        isi_valid;
  logic [15:0] spike_count;
  logic        overflow;
  logic        burst;

  int pass_cnt = 0;
  int total    = 0;

  spike_train_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .v_in        (v_in),
    .clear_stats (clear_stats),
    .spike       (spike),
    .isi_data    (isi_data),
    .isi_valid   (isi_valid),
    .isi_ready   (isi_ready),
    .spike_count (spike_count),
    .overflow    (overflow),
    .burst       (burst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; v_in = 8'h00; clear_stats = 1'b0; isi_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One firing sample followed by gap-1 sub-threshold samples.
  task automatic emit(input int gap, input bit rdy);
    en = 1'b1; v_in = 8'h20; isi_ready = rdy;
    tick();
    isi_ready = 1'b0; v_in = 8'hE0;
    repeat (gap - 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++; if ({spike, isi_valid, overflow, burst} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {spike, isi_valid, overflow, burst}); else pass_cnt++;
    total++; if (spike_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", spike_count); else pass_cnt++;
    total++; if (isi_data !== 16'd0) $display("FAIL reset_data: got %0d expected 0", isi_data); else pass_cnt++;
    rst = 1'b0; tick();
    emit(3, 1'b0); emit(3, 1'b0);
    en = 1'b1; v_in = 8'h20; tick();
    total++; if (spike !== 1'b1) $display("FAIL pre_async_spike: got %b expected 1", spike); else pass_cnt++;
    total++; if (isi_data !== 16'd3) $display("FAIL pre_async_data: got %0d expected 3", isi_data); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++; if ({spike, isi_valid, overflow, burst} !== 4'b0) $display("FAIL async_flags: got %b expected 0000", {spike, isi_valid, overflow, burst}); else pass_cnt++;
    total++; if (spike_count !== 16'd0) $display("FAIL async_count: got %0d expected 0", spike_count); else pass_cnt++;
    total++; if (isi_data !== 16'd0) $display("FAIL async_data: got %0d expected 0", isi_data); else pass_cnt++;
    rst = 1'b0;
    tick();
    total++; if (spike !== 1'b1) $display("FAIL armed_after_reset: got %b expected 1", spike); else pass_cnt++;
    total++; if (spike_count !== 16'd1) $display("FAIL count_after_reset: got %0d expected 1", spike_count); else pass_cnt++;
  endtask

  task automatic test_regular_train();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      v_in = (k % 10 == 0) ? 8'h20 : 8'hE0;
      tick();
      total++; if (spike !== (k % 10 == 0)) $display("FAIL train_spike k=%0d: got %b expected %b", k, spike, (k % 10 == 0)); else pass_cnt++;
      if (k % 10 == 0) begin
        total++; if (spike_count !== 16'(k / 10 + 1)) $display("FAIL train_count k=%0d: got %0d expected %0d", k, spike_count, k / 10 + 1); else pass_cnt++;
      end
      if (k == 0) begin
        total++; if (isi_valid !== 1'b0) $display("FAIL train_first_push: got %b expected 0", isi_valid); else pass_cnt++;
      end
      if (k == 10) begin
        total++; if (isi_valid !== 1'b1) $display("FAIL train_valid: got %b expected 1", isi_valid); else pass_cnt++;
        total++; if (isi_data !== 16'd10) $display("FAIL train_isi: got %0d expected 10", isi_data); else pass_cnt++;
      end
    end
    en = 1'b0; isi_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      total++; if (isi_valid !== 1'b1 || isi_data !== 16'd10) $display("FAIL train_drain p=%0d: got valid=%b data=%0d expected valid=1 data=10", p, isi_valid, isi_data); else pass_cnt++;
      tick();
    end
    total++; if (isi_valid !== 1'b0) $display("FAIL train_empty: got %b expected 0", isi_valid); else pass_cnt++;
    isi_ready = 1'b0;
  endtask

  task automatic test_hysteresis();
    logic [7:0] hv [5];
    logic       he [5];
    hv = '{8'h20, 8'h08, 8'h20, 8'hF0, 8'h20};
    he = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v_in = hv[i];
      tick();
      total++; if (spike !== he[i]) $display("FAIL hyst_spike i=%0d: got %b expected %b", i, spike, he[i]); else pass_cnt++;
    end
    total++; if (spike_count !== 16'd2) $display("FAIL hyst_count: got %0d expected 2", spike_count); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    logic [15:0] exp_d [3];
    exp_d = '{16'd4, 16'd5, 16'd6};
    do_reset();
    emit(2, 1'b0); emit(3, 1'b0); emit(4, 1'b0); emit(5, 1'b0); emit(6, 1'b0);
    total++; if (isi_data !== 16'd2 || isi_valid !== 1'b1) $display("FAIL full_head: got valid=%b data=%0d expected valid=1 data=2", isi_valid, isi_data); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL full_no_ovf: got %b expected 0", overflow); else pass_cnt++;
    emit(7, 1'b1);
    total++; if (isi_data !== 16'd3) $display("FAIL full_pushpop_head: got %0d expected 3", isi_data); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL full_pushpop_ovf: got %b expected 0", overflow); else pass_cnt++;
    emit(1, 1'b0);
    total++; if (overflow !== 1'b1) $display("FAIL full_drop_ovf: got %b expected 1", overflow); else pass_cnt++;
    total++; if (spike_count !== 16'd7) $display("FAIL full_count: got %0d expected 7", spike_count); else pass_cnt++;
    en = 1'b0; isi_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      total++; if (isi_valid !== 1'b1 || isi_data !== exp_d[p]) $display("FAIL full_drain p=%0d: got valid=%b data=%0d expected valid=1 data=%0d", p, isi_valid, isi_data, exp_d[p]); else pass_cnt++;
    end
    tick();
    total++; if (isi_valid !== 1'b0) $display("FAIL full_empty: got %b expected 0", isi_valid); else pass_cnt++;
    total++; if (overflow !== 1'b1) $display("FAIL full_ovf_sticky: got %b expected 1", overflow); else pass_cnt++;
    isi_ready = 1'b0;
  endtask

  task automatic test_sat_clear();
    do_reset();
    emit(1, 1'b0);
    v_in = 8'hE0;
    repeat (70000) tick();
    v_in = 8'h20; tick();
    total++; if (isi_valid !== 1'b1 || isi_data !== 16'hFFFF) $display("FAIL sat_isi: got valid=%b data=%0h expected valid=1 data=ffff", isi_valid, isi_data); else pass_cnt++;
    v_in = 8'hE0; tick();
    v_in = 8'h20; clear_stats = 1'b1; tick();
    clear_stats = 1'b0;
    total++; if (spike !== 1'b1) $display("FAIL clear_spike: got %b expected 1", spike); else pass_cnt++;
    total++; if (spike_count !== 16'd0) $display("FAIL clear_count: got %0d expected 0", spike_count); else pass_cnt++;
    total++; if (isi_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL clear_fifo: got valid=%b ovf=%b expected 0 0", isi_valid, overflow); else pass_cnt++;
    v_in = 8'hE0; tick();
    emit(4, 1'b0);
    total++; if (spike_count !== 16'd1 || isi_valid !== 1'b0) $display("FAIL clear_first_fire: got count=%0d valid=%b expected 1 0", spike_count, isi_valid); else pass_cnt++;
    emit(1, 1'b0);
    total++; if (isi_data !== 16'd4 || spike_count !== 16'd2) $display("FAIL clear_next_isi: got data=%0d count=%0d expected 4 2", isi_data, spike_count); else pass_cnt++;
  endtask

  task automatic test_burst();
    logic exp_b;
    do_reset();
    emit(5, 1'b0); emit(5, 1'b0); emit(5, 1'b0);
    total++; if (burst !== 1'b0) $display("FAIL burst_two_short: got %b expected 0", burst); else pass_cnt++;
    emit(20, 1'b0);
    exp_b = BURST_ON;
    total++; if (burst !== exp_b) $display("FAIL burst_three_short: got %b expected %b", burst, exp_b); else pass_cnt++;
    emit(1, 1'b0);
    total++; if (burst !== 1'b0) $display("FAIL burst_long: got %b expected 0", burst); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_regular_train();
    test_hysteresis();
    test_fifo_full();
    test_sat_clear();
    test_burst();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
